// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a MIPS-subset datapath: sequences fetch, decode,
// execute, memory access and write-back over one shared memory port.
module multicycle_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic        wr_sel,
    output logic        mem_to_reg,
    output logic        alu_src_imm,
    output logic        ext_sign,
    output logic [2:0]  alu_op,
    output logic        illegal,
    output logic        mem_err,
    output logic [31:0] retired
);

    localparam int WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);
    localparam logic [WW-1:0] WAIT_ONE = WW'(1);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        IC_ILL   = 3'd0,
        IC_RTYPE = 3'd1,
        IC_IALU  = 3'd2,
        IC_LW    = 3'd3,
        IC_SW    = 3'd4,
        IC_BEQ   = 3'd5,
        IC_J     = 3'd6
    } iclass_e;

    state_e        state_r;
    state_e        state_nx_s;
    logic [WW-1:0] wait_cnt_r;
    logic [WW-1:0] wait_cnt_nx_s;
    logic [31:0]   retired_r;
    logic          illegal_r;
    logic          mem_err_r;
    logic          retire_s;
    logic          set_ill_s;
    logic          set_err_s;
    logic          timeout_s;
    state_e        boundary_s;
    iclass_e       cls_s;
    logic [2:0]    dec_alu_s;
    logic          dec_imm_s;
    logic          dec_sext_s;
    logic [5:0]    opc_s;
    logic [5:0]    fn_s;
    logic          instr_unused_s;

    assign opc_s          = instr[31:26];
    assign fn_s           = instr[5:0];
    assign instr_unused_s = ^instr[25:6];

    assign timeout_s  = (wait_cnt_r == WAIT_LIM) && !mem_ready;
    assign boundary_s = run ? S_FETCH : S_IDLE;

    assign retired = retired_r;
    assign illegal = illegal_r;
    assign mem_err = mem_err_r;

    // Classify the instruction held in the IR and pick its ALU controls.
    always_comb begin
        cls_s      = IC_ILL;
        dec_alu_s  = ALU_ADD;
        dec_imm_s  = 1'b0;
        dec_sext_s = 1'b0;
        case (opc_s)
            6'b000000: begin
                case (fn_s)
                    6'b100000: begin cls_s = IC_RTYPE; dec_alu_s = ALU_ADD; end
                    6'b100010: begin cls_s = IC_RTYPE; dec_alu_s = ALU_SUB; end
                    6'b100100: begin cls_s = IC_RTYPE; dec_alu_s = ALU_AND; end
                    6'b100101: begin cls_s = IC_RTYPE; dec_alu_s = ALU_OR;  end
                    6'b101010: begin cls_s = IC_RTYPE; dec_alu_s = ALU_SLT; end
                    default:   cls_s = IC_ILL;
                endcase
            end
            6'b001000: begin cls_s = IC_IALU; dec_alu_s = ALU_ADD; dec_imm_s = 1'b1; dec_sext_s = 1'b1; end
            6'b001010: begin cls_s = IC_IALU; dec_alu_s = ALU_SLT; dec_imm_s = 1'b1; dec_sext_s = 1'b1; end
            6'b001100: begin cls_s = IC_IALU; dec_alu_s = ALU_AND; dec_imm_s = 1'b1; end
            6'b001101: begin cls_s = IC_IALU; dec_alu_s = ALU_OR;  dec_imm_s = 1'b1; end
            6'b100011: begin cls_s = IC_LW;   dec_alu_s = ALU_ADD; dec_imm_s = 1'b1; dec_sext_s = 1'b1; end
            6'b101011: begin cls_s = IC_SW;   dec_alu_s = ALU_ADD; dec_imm_s = 1'b1; dec_sext_s = 1'b1; end
            6'b000100: begin cls_s = IC_BEQ;  dec_alu_s = ALU_SUB; end
            6'b000010: cls_s = IC_J;
            default:   cls_s = IC_ILL;
        endcase
    end

    // Next-state and control decode; only ir_we, pc_we and the FETCH/MEM exits see mem_ready/zero.
    always_comb begin
        state_nx_s   = state_r;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        reg_we       = 1'b0;
        wr_sel       = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_imm  = 1'b0;
        ext_sign     = 1'b0;
        alu_op       = ALU_ADD;
        retire_s     = 1'b0;
        set_ill_s    = 1'b0;
        set_err_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    state_nx_s = S_FETCH;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_nx_s = S_DECODE;
                end else if (timeout_s) begin
                    set_err_s  = 1'b1;
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (cls_s == IC_ILL) begin
                    set_ill_s  = 1'b1;
                    state_nx_s = boundary_s;
                end else begin
                    state_nx_s = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op      = dec_alu_s;
                alu_src_imm = dec_imm_s;
                ext_sign    = dec_sext_s;
                case (cls_s)
                    IC_RTYPE, IC_IALU: state_nx_s = S_WB;
                    IC_LW, IC_SW:      state_nx_s = S_MEM;
                    IC_BEQ: begin
                        pc_src     = 2'd1;
                        pc_we      = zero;
                        retire_s   = 1'b1;
                        state_nx_s = boundary_s;
                    end
                    IC_J: begin
                        pc_src     = 2'd2;
                        pc_we      = 1'b1;
                        retire_s   = 1'b1;
                        state_nx_s = boundary_s;
                    end
                    default: state_nx_s = boundary_s;
                endcase
            end
            S_MEM: begin
                // ALU keeps producing the effective address while the access is pending.
                alu_op       = dec_alu_s;
                alu_src_imm  = dec_imm_s;
                ext_sign     = dec_sext_s;
                mem_addr_sel = 1'b1;
                mem_rd       = (cls_s == IC_LW);
                mem_wr       = (cls_s == IC_SW);
                if (mem_ready) begin
                    if (cls_s == IC_LW) begin
                        state_nx_s = S_WB;
                    end else begin
                        retire_s   = 1'b1;
                        state_nx_s = boundary_s;
                    end
                end else if (timeout_s) begin
                    set_err_s  = 1'b1;
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_MEM;
                end
            end
            S_WB: begin
                alu_op      = dec_alu_s;
                alu_src_imm = dec_imm_s;
                ext_sign    = dec_sext_s;
                reg_we      = 1'b1;
                wr_sel      = (cls_s == IC_RTYPE);
                mem_to_reg  = (cls_s == IC_LW);
                retire_s    = 1'b1;
                state_nx_s  = boundary_s;
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Wait counter runs only while a memory request is stalled and clears on any state change.
    always_comb begin
        if (state_nx_s != state_r) begin
            wait_cnt_nx_s = {WW{1'b0}};
        end else if (((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready) begin
            wait_cnt_nx_s = wait_cnt_r + WAIT_ONE;
        end else begin
            wait_cnt_nx_s = wait_cnt_r;
        end
    end

    // State, wait counter, retire counter and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= {WW{1'b0}};
            retired_r  <= 32'd0;
            illegal_r  <= 1'b0;
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_cnt_nx_s;
            if (retire_s) begin
                retired_r <= retired_r + 32'd1;
            end
            if (set_ill_s) begin
                illegal_r <= 1'b1;
            end
            if (set_err_s) begin
                mem_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: random instruction streams with random
// memory waits, checked against an instruction-level latency/effect model.
module tb_multicycle_ctrl;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        mem_rd, mem_wr, mem_addr_sel, ir_we, pc_we;
    logic [1:0]  pc_src;
    logic        reg_we, wr_sel, mem_to_reg, alu_src_imm, ext_sign;
    logic [2:0]  alu_op;
    logic        illegal, mem_err;
    logic [31:0] retired;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] ret_exp;
    logic        ill_exp;
    logic        err_exp;

    typedef enum int {K_R, K_ADDI, K_SLTI, K_ANDI, K_ORI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

    multicycle_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .instr(instr),
        .mem_ready(mem_ready), .zero(zero),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr_sel(mem_addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .wr_sel(wr_sel), .mem_to_reg(mem_to_reg), .alu_src_imm(alu_src_imm),
        .ext_sign(ext_sign), .alu_op(alu_op), .illegal(illegal),
        .mem_err(mem_err), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic kind_t classify(input logic [31:0] w);
        logic [5:0] fn;
        fn = w[5:0];
        case (w[31:26])
            6'b000000: classify = (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                                   fn == 6'b100101 || fn == 6'b101010) ? K_R : K_ILL;
            6'b001000: classify = K_ADDI;
            6'b001010: classify = K_SLTI;
            6'b001100: classify = K_ANDI;
            6'b001101: classify = K_ORI;
            6'b100011: classify = K_LW;
            6'b101011: classify = K_SW;
            6'b000100: classify = K_BEQ;
            6'b000010: classify = K_J;
            default:   classify = K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] exp_alu(input logic [31:0] w);
        case (classify(w))
            K_R: begin
                case (w[5:0])
                    6'b100010: exp_alu = 3'd1;
                    6'b100100: exp_alu = 3'd2;
                    6'b100101: exp_alu = 3'd3;
                    6'b101010: exp_alu = 3'd4;
                    default:   exp_alu = 3'd0;
                endcase
            end
            K_SLTI:  exp_alu = 3'd4;
            K_ANDI:  exp_alu = 3'd2;
            K_ORI:   exp_alu = 3'd3;
            K_BEQ:   exp_alu = 3'd1;
            default: exp_alu = 3'd0;
        endcase
    endfunction

    function automatic logic [31:0] make_word(input int sel);
        logic [31:0] w;
        w = $urandom;
        case (sel)
            0: begin
                w[31:26] = 6'b000000;
                case ($urandom_range(0, 4))
                    0: w[5:0] = 6'b100000;
                    1: w[5:0] = 6'b100010;
                    2: w[5:0] = 6'b100100;
                    3: w[5:0] = 6'b100101;
                    default: w[5:0] = 6'b101010;
                endcase
            end
            1: w[31:26] = 6'b001000;
            2: w[31:26] = 6'b001010;
            3: w[31:26] = 6'b001100;
            4: w[31:26] = 6'b001101;
            5: w[31:26] = 6'b100011;
            6: w[31:26] = 6'b101011;
            7: w[31:26] = 6'b000100;
            8: w[31:26] = 6'b000010;
            9: begin
                w[31:26] = 6'b000000;
                while (classify(w) != K_ILL) w[5:0] = 6'($urandom);
            end
            default: begin
                while (classify(w) != K_ILL) w = $urandom;
            end
        endcase
        return w;
    endfunction

    // Runs one instruction starting at the negedge of its first FETCH cycle.
    task automatic run_one(input logic [31:0] w, input int fw, input int mw,
                           input logic z, input bit drop, input string tag);
        kind_t      k;
        int         cyc, n_ir, n_pc, n_reg, n_frd, n_mrd, n_mwr, n_both, n_dec_bad;
        int         fwl, mwl, lat, limit, exp_pc;
        bit         seen_ir, ir_now;
        logic [2:0] ex_alu;
        logic       ex_imm, ex_sext, wb_wrsel, wb_m2r;
        logic [1:0] ex_pcsrc;
        k = classify(w);
        cyc = 0; n_ir = 0; n_pc = 0; n_reg = 0; n_frd = 0; n_mrd = 0; n_mwr = 0;
        n_both = 0; n_dec_bad = 0; fwl = fw; mwl = mw; seen_ir = 0;
        ex_alu = 3'd7; ex_imm = 1'bx; ex_sext = 1'bx; ex_pcsrc = 2'd3;
        wb_wrsel = 1'bx; wb_m2r = 1'bx;
        limit = drop ? 16 : 60;
        for (int c = 0; c < limit; c++) begin
            if (!drop && seen_ir && mem_rd && !mem_addr_sel) break;
            zero = z;
            if (mem_rd || mem_wr) begin
                if (!mem_addr_sel) begin
                    mem_ready = (fwl == 0);
                    if (fwl > 0) fwl--;
                end else begin
                    mem_ready = (mwl == 0);
                    if (mwl > 0) mwl--;
                end
            end else begin
                mem_ready = 1'b0;
            end
            #1;
            if (mem_rd && mem_wr) n_both++;
            if (reg_we && pc_we) n_both++;
            if (mem_rd && !mem_addr_sel) n_frd++;
            if (mem_rd && mem_addr_sel) n_mrd++;
            if (mem_wr) n_mwr++;
            if (pc_we) n_pc++;
            if (reg_we) begin
                n_reg++;
                wb_wrsel = wr_sel;
                wb_m2r = mem_to_reg;
            end
            if (c == fw + 1 && (mem_rd || mem_wr || reg_we || pc_we || ir_we)) n_dec_bad++;
            if (c == fw + 2) begin
                ex_alu = alu_op; ex_imm = alu_src_imm; ex_sext = ext_sign; ex_pcsrc = pc_src;
            end
            if (drop && c == fw + 1) run = 1'b0;
            ir_now = ir_we;
            if (ir_we) n_ir++;
            cyc++;
            @(posedge clk);
            if (ir_now) begin
                instr = w;
                seen_ir = 1;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        // Instruction-level expectations.
        case (k)
            K_LW:         lat = 5 + fw + mw;
            K_SW:         lat = 4 + fw + mw;
            K_BEQ, K_J:   lat = 3 + fw;
            K_ILL:        lat = 2 + fw;
            default:      lat = 4 + fw;
        endcase
        exp_pc = 1 + ((k == K_J) ? 1 : 0) + ((k == K_BEQ && z) ? 1 : 0);
        if (k == K_ILL) ill_exp = 1'b1;
        else ret_exp = ret_exp + 32'd1;

        if (!drop) begin
            checks++;
            if (cyc !== lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, lat); end
        end else begin
            checks++;
            if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
                errors++; $display("FAIL %s parked: got rd=%b wr=%b want 0 0", tag, mem_rd, mem_wr);
            end
        end
        checks++;
        if (n_frd !== fw + 1) begin errors++; $display("FAIL %s fetch_cycles: got %0d want %0d", tag, n_frd, fw + 1); end
        checks++;
        if (n_ir !== 1) begin errors++; $display("FAIL %s ir_we_count: got %0d want 1", tag, n_ir); end
        checks++;
        if (n_pc !== exp_pc) begin errors++; $display("FAIL %s pc_we_count: got %0d want %0d", tag, n_pc, exp_pc); end
        checks++;
        if (n_reg !== ((k == K_R || k == K_ADDI || k == K_SLTI || k == K_ANDI || k == K_ORI || k == K_LW) ? 1 : 0)) begin
            errors++; $display("FAIL %s reg_we_count: got %0d kind %0d", tag, n_reg, k);
        end
        checks++;
        if (n_mrd !== ((k == K_LW) ? mw + 1 : 0)) begin
            errors++; $display("FAIL %s mem_rd_data_cycles: got %0d want %0d", tag, n_mrd, (k == K_LW) ? mw + 1 : 0);
        end
        checks++;
        if (n_mwr !== ((k == K_SW) ? mw + 1 : 0)) begin
            errors++; $display("FAIL %s mem_wr_cycles: got %0d want %0d", tag, n_mwr, (k == K_SW) ? mw + 1 : 0);
        end
        checks++;
        if (n_both !== 0) begin errors++; $display("FAIL %s exclusive_strobes: got %0d overlaps want 0", tag, n_both); end
        checks++;
        if (n_dec_bad !== 0) begin errors++; $display("FAIL %s decode_quiet: got %0d strobes want 0", tag, n_dec_bad); end
        if (k != K_J && k != K_ILL) begin
            checks++;
            if (ex_alu !== exp_alu(w)) begin errors++; $display("FAIL %s exec_alu_op: got %0d want %0d", tag, ex_alu, exp_alu(w)); end
            checks++;
            if (ex_imm !== ((k == K_R || k == K_BEQ) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL %s exec_alu_src_imm: got %b kind %0d", tag, ex_imm, k);
            end
        end
        if (k == K_ADDI || k == K_SLTI || k == K_LW || k == K_SW || k == K_ANDI || k == K_ORI) begin
            checks++;
            if (ex_sext !== ((k == K_ANDI || k == K_ORI) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL %s exec_ext_sign: got %b kind %0d", tag, ex_sext, k);
            end
        end
        if (k == K_BEQ || k == K_J) begin
            checks++;
            if (ex_pcsrc !== ((k == K_J) ? 2'd2 : 2'd1)) begin
                errors++; $display("FAIL %s exec_pc_src: got %0d want %0d", tag, ex_pcsrc, (k == K_J) ? 2 : 1);
            end
        end
        if (n_reg == 1) begin
            checks++;
            if (wb_wrsel !== (k == K_R) || wb_m2r !== (k == K_LW)) begin
                errors++; $display("FAIL %s wb_select: got wr_sel=%b mem_to_reg=%b want %b %b",
                                   tag, wb_wrsel, wb_m2r, (k == K_R), (k == K_LW));
            end
        end
        checks++;
        if (retired !== ret_exp) begin errors++; $display("FAIL %s retired: got %0d want %0d", tag, retired, ret_exp); end
        checks++;
        if (illegal !== ill_exp || mem_err !== err_exp) begin
            errors++; $display("FAIL %s sticky_flags: got ill=%b err=%b want %b %b", tag, illegal, mem_err, ill_exp, err_exp);
        end
    endtask

    task automatic resume_run();
        run = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; instr = 32'd0; mem_ready = 1'b0; zero = 1'b0;
        ret_exp = 32'd0; ill_exp = 1'b0; err_exp = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_rd, mem_wr, mem_addr_sel, ir_we, pc_we, reg_we, wr_sel, mem_to_reg, alu_src_imm, ext_sign} !== 10'd0 ||
            pc_src !== 2'd0 || alu_op !== 3'd0) begin
            errors++; $display("FAIL reset_outputs: got strobes nonzero pc_src=%0d alu_op=%0d want all 0", pc_src, alu_op);
        end
        checks++;
        if (retired !== 32'd0 || illegal !== 1'b0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL reset_status: got ret=%0d ill=%b err=%b want 0 0 0", retired, illegal, mem_err);
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b0) begin errors++; $display("FAIL idle_without_run: got mem_rd=%b want 0", mem_rd); end
        resume_run();
        checks++;
        if (mem_rd !== 1'b1 || mem_addr_sel !== 1'b0) begin
            errors++; $display("FAIL fetch_start: got rd=%b sel=%b want 1 0", mem_rd, mem_addr_sel);
        end
    endtask

    task automatic test_directed();
        run_one(32'h012A4020, 0, 0, 1'b0, 1'b0, "add");
        run_one(32'h8D280004, 0, 3, 1'b0, 1'b0, "lw_wait3");
        run_one(32'h11090003, 0, 0, 1'b1, 1'b0, "beq_taken");
        run_one(32'h11090003, 0, 0, 1'b0, 1'b0, "beq_not_taken");
        run_one(32'hFC000000, 0, 0, 1'b0, 1'b0, "illegal_op");
        run_one(32'h08000010, 2, 0, 1'b0, 1'b0, "j_fetchwait");
        run_one(32'hAD280008, 1, 2, 1'b0, 1'b0, "sw_waits");
    endtask

    task automatic test_random();
        logic [31:0] w;
        bit          drop;
        for (int i = 0; i < 150; i++) begin
            w = make_word($urandom_range(0, 10));
            drop = ((i % 10) == 9);
            run_one(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), drop, "random");
            if (drop) resume_run();
        end
    endtask

    task automatic test_timeout();
        int n;
        logic [31:0] ret_before;
        run_one(32'h2128FFFF, WAIT_MAX, 0, 1'b0, 1'b0, "fetch_wait_max_ok");
        ret_before = retired;
        run = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            mem_ready = 1'b0;
            #1;
            if (!mem_rd) break;
            n++;
            @(posedge clk);
            @(negedge clk);
        end
        err_exp = 1'b1;
        checks++;
        if (n !== WAIT_MAX + 1) begin errors++; $display("FAIL timeout_request_cycles: got %0d want %0d", n, WAIT_MAX + 1); end
        checks++;
        if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_mem_err: got %b want 1", mem_err); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b0 || ir_we !== 1'b0 || retired !== ret_before) begin
            errors++; $display("FAIL timeout_idle: got rd=%b ir_we=%b ret=%0d want 0 0 %0d", mem_rd, ir_we, retired, ret_before);
        end
    endtask

    task automatic test_reset_mid_sw();
        int quiet_bad;
        resume_run();
        mem_ready = 1'b1;
        #1;
        @(posedge clk);
        instr = 32'hAD280008;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        checks++;
        if (mem_wr !== 1'b1 || mem_addr_sel !== 1'b1) begin
            errors++; $display("FAIL sw_in_mem: got wr=%b sel=%b want 1 1", mem_wr, mem_addr_sel);
        end
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        checks++;
        if ({mem_rd, mem_wr, mem_addr_sel, ir_we, pc_we, reg_we, wr_sel, mem_to_reg, alu_src_imm, ext_sign} !== 10'd0 ||
            pc_src !== 2'd0 || alu_op !== 3'd0) begin
            errors++; $display("FAIL midsw_reset_outputs: got nonzero strobes pc_src=%0d alu_op=%0d want 0", pc_src, alu_op);
        end
        checks++;
        if (retired !== 32'd0 || illegal !== 1'b0 || mem_err !== 1'b0) begin
            errors++; $display("FAIL midsw_reset_status: got ret=%0d ill=%b err=%b want 0 0 0", retired, illegal, mem_err);
        end
        ret_exp = 32'd0; ill_exp = 1'b0; err_exp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_bad = 0;
        for (int c = 0; c < 5; c++) begin
            mem_ready = 1'b1;
            #1;
            if (mem_rd || mem_wr || reg_we || pc_we || ir_we) quiet_bad++;
            @(posedge clk);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        checks++;
        if (quiet_bad !== 0) begin errors++; $display("FAIL run_low_stays_idle: got %0d active cycles want 0", quiet_bad); end
        resume_run();
        run_one(32'h012A4022, 1, 0, 1'b0, 1'b0, "post_reset_sub");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_reset_mid_sw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no completion want summary before time limit");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the MIPS-subset datapath. It sequences instruction fetch, register-file read, ALU execute, data-memory access and register write-back. It drives every enable and select of the decode/execute datapath: the register file WE, the write-address mux select and the immediate-extension mode. It sits beside the instruction register, decodes opcode/funct from it, and handshakes with a single shared memory port.

## Interface
- WAIT_MAX, 15, memory wait cycles tolerated per access before `mem_err` is raised.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute instructions, 0 = park in IDLE at next instruction boundary.
- instr  in  32  instruction register contents (valid from DECODE onward).
- mem_ready  in  1  memory port completion strobe.
- zero  in  1  ALU zero flag.
- mem_rd, mem_wr  out  1  memory read/write request.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  latch fetched word into instruction register.
- pc_we  out  1  PC update enable.
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target.
- reg_we  out  1  register file write enable.
- wr_sel  out  1  write-address mux: 1 = rd (instr[15:11]), 0 = rt (instr[20:16]).
- mem_to_reg  out  1  write-back data: 1 = memory data, 0 = ALU result.
- alu_src_imm  out  1  ALU B operand: 1 = extended immediate, 0 = Dr2.
- ext_sign  out  1  1 = sign-extend imm16, 0 = zero-extend.
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- illegal  out  1  sticky unsupported-instruction flag.
- mem_err  out  1  sticky memory-timeout flag.
- retired  out  32  count of completed instructions.

## Operation
- States: IDLE(0), FETCH(1), DECODE(2), EXEC(3), MEM(4), WB(5). Encoding is 3 bits and registered.
- IDLE: all strobes are 0. The FSM moves to FETCH when `run`=1.
- FETCH: `mem_rd`=1, `mem_addr_sel`=0. While `mem_ready`=0 the FSM holds and the wait counter increments. When `mem_ready`=1: `ir_we`=1, `pc_we`=1, `pc_src`=0, and the FSM moves to DECODE.
- DECODE: no strobes. The opcode is checked.
  - Supported: R-type (000000) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010. Also addi 001000, slti 001010, andi 001100, ori 001101, lw 100011, sw 101011, beq 000100, j 000010.
  - Supported instruction: go to EXEC.
  - Unsupported opcode/funct: set `illegal`, increment nothing, go to FETCH (IDLE if `run`=0).
- EXEC:
  - R-type: `alu_op` from funct, `alu_src_imm`=0; go to WB.
  - addi/slti: ADD/SLT, `alu_src_imm`=1, `ext_sign`=1; go to WB.
  - andi/ori: AND/OR, `alu_src_imm`=1, `ext_sign`=0; go to WB.
  - lw/sw: ADD, `alu_src_imm`=1, `ext_sign`=1; go to MEM.
  - beq: SUB, `alu_src_imm`=0, `pc_src`=1, `pc_we`=`zero`; instruction retires; go to FETCH/IDLE.
  - j: `pc_src`=2, `pc_we`=1; instruction retires; go to FETCH/IDLE.
- MEM:
  - Address and request: `mem_addr_sel`=1; `mem_rd`=1 for lw, `mem_wr`=1 for sw; hold until `mem_ready`.
  - Completion: lw goes to WB; sw retires and goes to FETCH/IDLE.
- WB: `reg_we`=1 for exactly one cycle. `wr_sel`=1 for R-type, 0 otherwise; `mem_to_reg`=1 only for lw. The instruction retires; go to FETCH/IDLE.
- Control outputs are Moore-decoded from state plus `instr`. Only `ir_we`, `pc_we` and the FETCH/MEM exits depend combinationally on `mem_ready`/`zero`.
- `retired` increments by 1 in the retiring cycle and wraps from 0xFFFFFFFF to 0.
- Timeout: if the wait counter reaches WAIT_MAX with `mem_ready` still 0, set `mem_err`, drop the request and go to IDLE. The wait counter clears on every state change.
- `illegal` and `mem_err` clear only on reset.

## Timing
- Reset (async, rst_n=0) forces:
  - state IDLE;
  - all outputs 0 (`alu_op`=0, `pc_src`=0), `retired`=0, `illegal`=0, `mem_err`=0, wait counter 0.
- Reset asserted mid-instruction aborts immediately; no `reg_we`/`pc_we` is emitted afterward.
- Latency with zero-wait memory (mem_ready=1 on request cycle), in cycles FETCH-to-FETCH: R/I-ALU 4, lw 5, sw 4, beq 3, j 3, illegal 2. Each memory wait cycle adds 1.
- `run` is sampled only on exit from IDLE and at instruction boundaries. Dropping `run` mid-instruction completes the current instruction.
- `mem_rd` and `mem_wr` are never both 1. `reg_we` and `pc_we` are never both 1.

## Test plan
- Reset, then `run`=1 with instr=0x012A4020 (add $8,$9,$10) and zero-wait memory -> FETCH, DECODE, EXEC, WB over 4 cycles. In WB: `reg_we`=1, `wr_sel`=1, `alu_op`=0. Then `retired`=1.
- instr=0x8D280004 (lw $8,4($9)) with mem_ready delayed 3 cycles in MEM -> `mem_rd` is held 4 cycles with `mem_addr_sel`=1. WB has `mem_to_reg`=1, `wr_sel`=0. Total 8 cycles.
- instr=0x11090003 (beq): with zero=1, `pc_we`=1 and `pc_src`=1 in EXEC; with zero=0, `pc_we`=0. `retired` increments in both cases.
- instr=0xFC000000 -> `illegal`=1 after DECODE, no `reg_we` pulse, next state FETCH, `retired` unchanged.
- mem_ready held 0 in FETCH -> `mem_err`=1 after 15 wait cycles, state IDLE, `mem_rd`=0.
- rst_n pulsed low during MEM of sw -> all outputs 0 immediately, `retired`=0. `run`=0 after reset -> the FSM stays in IDLE.
